// File: rtl/rep_id_generator.sv
// Doubled-ID stream generator: emits every number whose decimal digits are
// some X (no leading zero) written twice, in ascending order, for half-lengths
// 1 .. MAX_K/2. Producer side of a stall / out_valid / done stream.
// The datapath has no multipliers. x10 and x100 are built from shifts and
// adds. A single shared 64-bit adder forms both the first value of a length
// and each next value.
module rep_id_generator #(
  parameter int unsigned MAX_K = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [63:0] out_val,
  output logic        out_valid,
  output logic        done,
  output logic [31:0] out_count
);

  // Last half-length to emit. An odd MAX_K rounds down.
  localparam logic [4:0] LastH = 5'(MAX_K / 2);

  typedef enum logic [1:0] {
    StLoad,
    StEmit,
    StNextLen,
    StDone
  } state_t;

  state_t      r_state;
  logic [4:0]  r_h;      // current half-length
  logic [63:0] r_lo;     // 10^(h-1), smallest X of this length
  logic [63:0] r_hi;     // 10^h
  logic [63:0] r_big;    // 10^(2h-1)
  logic [63:0] r_x;      // current X
  logic [63:0] r_step;   // 10^h + 1, distance between consecutive values
  logic [63:0] r_val;
  logic        r_valid;
  logic        r_done;
  logic [31:0] r_count;

  logic [63:0] w_add_a;
  logic [63:0] w_add_b;
  logic [63:0] w_sum;
  logic [63:0] w_hi_x10;
  logic [63:0] w_big_x100;
  logic        w_last_x;

  // Shared adder: big + lo in LOAD gives the first value; val + step in EMIT gives the next.
  always_comb begin
    w_add_a = r_val;
    w_add_b = r_step;
    if (r_state == StLoad) begin
      w_add_a = r_big;
      w_add_b = r_lo;
    end
  end

  assign w_sum      = w_add_a + w_add_b;
  assign w_hi_x10   = (r_hi << 3) + (r_hi << 1);
  assign w_big_x100 = (r_big << 6) + (r_big << 5) + (r_big << 2);
  assign w_last_x   = (r_x == (r_hi - 64'd1));

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StLoad;
      r_h     <= 5'd1;
      r_lo    <= 64'd1;
      r_hi    <= 64'd10;
      r_big   <= 64'd10;
      r_x     <= 64'd0;
      r_step  <= 64'd0;
      r_val   <= 64'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_count <= 32'd0;
    end else begin
      unique case (r_state)
        StLoad: begin
          r_val   <= w_sum;
          r_step  <= r_hi + 64'd1;
          r_x     <= r_lo;
          r_valid <= 1'b1;
          r_state <= StEmit;
        end
        StEmit: begin
          // out_valid is always high in EMIT, so an edge with stall low is an accept.
          if (!stall) begin
            r_count <= r_count + 32'd1;
            if (w_last_x) begin
              r_valid <= 1'b0;
              r_state <= (r_h == LastH) ? StDone : StNextLen;
            end else begin
              r_x   <= r_x + 64'd1;
              r_val <= w_sum;
            end
          end
        end
        StNextLen: begin
          r_h     <= r_h + 5'd1;
          r_lo    <= r_hi;
          r_hi    <= w_hi_x10;
          r_big   <= w_big_x100;
          r_state <= StLoad;
        end
        StDone: begin
          // Sticky until reset. out_val keeps the final value.
          r_done  <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_val   = r_val;
  assign out_valid = r_valid;
  assign done      = r_done;
  assign out_count = r_count;

endmodule

// File: tb/tb_rep_id_generator.sv
// Directed bench for rep_id_generator. It runs three instances (MAX_K = 2, 4, 6)
// on a shared clock and reset. Expected values are derived as X*(10^h+1).
module tb_rep_id_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall2, stall4, stall6;
  logic [63:0] v2, v4, v6;
  logic        vl2, vl4, vl6;
  logic        d2, d4, d6;
  logic [31:0] c2, c4, c6;

  rep_id_generator #(.MAX_K(2)) u_k2 (
    .clk(clk), .rst(rst), .stall(stall2),
    .out_val(v2), .out_valid(vl2), .done(d2), .out_count(c2)
  );
  rep_id_generator #(.MAX_K(4)) u_k4 (
    .clk(clk), .rst(rst), .stall(stall4),
    .out_val(v4), .out_valid(vl4), .done(d4), .out_count(c4)
  );
  rep_id_generator #(.MAX_K(6)) u_k6 (
    .clk(clk), .rst(rst), .stall(stall6),
    .out_val(v6), .out_valid(vl6), .done(d6), .out_count(c6)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Selects which instance the generic free-run task observes.
  int          sel;
  logic [63:0] mon_val;
  logic        mon_valid;
  logic        mon_done;
  logic [31:0] mon_count;

  always_comb begin
    mon_val   = v6;
    mon_valid = vl6;
    mon_done  = d6;
    mon_count = c6;
    case (sel)
      2: begin mon_val = v2; mon_valid = vl2; mon_done = d2; mon_count = c2; end
      4: begin mon_val = v4; mon_valid = vl4; mon_done = d4; mon_count = c4; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Free-running check of one instance against the reference sequence.
  task automatic run_free(input int which, input int half, input logic [63:0] exp_sum,
                          input int max_cyc);
    logic [63:0] bx, last, sum;
    int          bh, n, gap;
    sel    = which;
    stall2 = 1'b0;
    stall4 = 1'b0;
    stall6 = 1'b0;
    do_reset();
    bx = 64'd1; bh = 1; n = 0; gap = 0; sum = 64'd0; last = 64'd0;
    for (int cyc = 0; cyc < max_cyc && bh <= half; cyc++) begin
      @(negedge clk);
      if (mon_valid) begin
        check("gap", 64'(gap), (n > 0 && bh > 1 && bx == pow10(bh - 1)) ? 64'd2 : 64'd0);
        check("val", mon_val, bx * (pow10(bh) + 64'd1));
        sum  = sum + mon_val;
        last = mon_val;
        n++;
        gap = 0;
        bx  = bx + 64'd1;
        if (bx == pow10(bh)) begin
          bh++;
          bx = pow10(bh - 1);
        end
      end else begin
        gap++;
      end
    end
    check("timeout", 64'(bh > half), 64'd1);
    @(negedge clk);
    check("end_valid", 64'(mon_valid), 64'd0);
    check("end_count", 64'(mon_count), 64'(n));
    check("end_count_abs", 64'(mon_count), pow10(half) - 64'd10 + 64'd9);
    check("end_done_early", 64'(mon_done), 64'd0);
    check("last_val", last, pow10(2 * half) - 64'd1);
    check("sum", sum, exp_sum);
    @(negedge clk);
    check("done", 64'(mon_done), 64'd1);
    check("hold_val", mon_val, pow10(2 * half) - 64'd1);
  endtask

  initial begin
    logic [63:0] bx;
    int          bh, held, found;
    logic        seen;

    rst    = 1'b0;
    stall2 = 1'b0;
    stall4 = 1'b0;
    stall6 = 1'b0;
    sel    = 2;

    // Reset values, including across a clock edge while held in reset.
    #12;
    @(negedge clk);
    check("rst_val2", v2, 64'd0);
    check("rst_valid2", 64'(vl2), 64'd0);
    check("rst_done2", 64'(d2), 64'd0);
    check("rst_count2", 64'(c2), 64'd0);
    check("rst_val4", v4, 64'd0);
    check("rst_valid4", 64'(vl4), 64'd0);
    check("rst_val6", v6, 64'd0);
    check("rst_valid6", 64'(vl6), 64'd0);
    rst = 1'b1;

    // MAX_K=2: 11..99 on consecutive cycles, then done.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check("k2_val", v2, 64'(11 * k));
      check("k2_valid", 64'(vl2), 64'd1);
      check("k2_count", 64'(c2), 64'(k - 1));
    end
    @(negedge clk);
    check("k2_end_valid", 64'(vl2), 64'd0);
    check("k2_end_count", 64'(c2), 64'd9);
    check("k2_end_val", v2, 64'd99);
    check("k2_done_early", 64'(d2), 64'd0);
    @(negedge clk);
    check("k2_done", 64'(d2), 64'd1);
    check("k2_valid_off", 64'(vl2), 64'd0);
    stall2 = 1'b1;
    repeat (3) @(negedge clk);
    check("k2_done_sticky", 64'(d2), 64'd1);
    check("k2_valid_stays_off", 64'(vl2), 64'd0);
    check("k2_count_stays", 64'(c2), 64'd9);
    stall2 = 1'b0;

    // MAX_K=4 full run: gap of 2 between lengths, sum 495900.
    run_free(4, 2, 64'd495900, 400);

    // Stall hold at 33.
    stall4 = 1'b0;
    do_reset();
    @(negedge clk);
    check("sh_11", v4, 64'd11);
    @(negedge clk);
    check("sh_22", v4, 64'd22);
    @(negedge clk);
    check("sh_33", v4, 64'd33);
    stall4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sh_hold_val", v4, 64'd33);
      check("sh_hold_valid", 64'(vl4), 64'd1);
      check("sh_hold_count", 64'(c4), 64'd2);
    end
    stall4 = 1'b0;
    @(negedge clk);
    check("sh_44", v4, 64'd44);
    check("sh_count", 64'(c4), 64'd3);

    // Consumer-style stall: stall while out_val > 5000 for 10 edges.
    do_reset();
    bx = 64'd1; bh = 1; held = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      @(negedge clk);
      if (vl4) begin
        check("cons_val", v4, bx * (pow10(bh) + 64'd1));
        if (v4 == 64'd5151) seen = 1'b1;
        if (v4 > 64'd5000 && held < 10) begin
          stall4 = 1'b1;
          held++;
        end else begin
          stall4 = 1'b0;
          bx = bx + 64'd1;
          if (bx == pow10(bh)) begin
            bh++;
            bx = pow10(bh - 1);
          end
        end
      end else begin
        stall4 = 1'b0;
      end
    end
    stall4 = 1'b0;
    check("cons_5151_seen", 64'(seen), 64'd1);
    check("cons_held", 64'(held), 64'd10);

    // Asynchronous reset mid-run at 2323.
    do_reset();
    found = 0;
    for (int cyc = 0; cyc < 100 && found == 0; cyc++) begin
      @(negedge clk);
      if (vl4 && v4 == 64'd2323) found = 1;
    end
    check("mr_found_2323", 64'(found), 64'd1);
    check("mr_k2_done_pre", 64'(d2), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mr_val", v4, 64'd0);
    check("mr_valid", 64'(vl4), 64'd0);
    check("mr_count", 64'(c4), 64'd0);
    check("mr_done", 64'(d4), 64'd0);
    check("mr_k2_done", 64'(d2), 64'd0);
    check("mr_k2_val", v2, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_restart_val", v4, 64'd11);
    check("mr_restart_valid", 64'(vl4), 64'd1);

    // MAX_K=6 full run: 999 values, last 999999.
    run_free(6, 3, 64'd495540450, 2500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rep_id_generator.md
Name: rep_id_generator

Overview:
- Producer end of the generator→solver stream interface (stall / out_val / out_valid / done).
- Emits, in strictly ascending order, every "doubled" ID: a decimal number whose digit string is some X (no leading zero) written twice, e.g. 11, 6464, 123123.
- Downstream range-matching logic compares each value against sorted ranges and accumulates matches.
- Multiplier-free: all values are built from shift-add ×10 / ×100 steps and one 64-bit adder.

Parameters:
- MAX_K, 12, maximum total digit count of any emitted value. Half-lengths emitted are h = 1 .. floor(MAX_K/2). Legal range 2..18; 18 keeps every value below 2^64.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset. Asserting low immediately forces the reset state; release is synchronous to clk.
- stall  input  1  consumer hold. May be driven combinationally from out_val by the consumer.
- out_val  output  64  current doubled ID.
- out_valid  output  1  out_val is meaningful.
- done  output  1  sequence exhausted; sticky until reset.
- out_count  output  32  number of values accepted so far.

Behaviour:
- Reset values:
  - outputs: out_val=0, out_valid=0, done=0, out_count=0.
  - internal state: state=LOAD, h=1, lo=1 (10^(h-1)), hi=10 (10^h), big=10 (10^(2h-1)), x=0, step=0.
- Accept rule: a value is accepted on any rising edge where out_valid=1 and stall=0.
  - On accept, out_count increments by 1 (wraps at 2^32; not reachable for legal MAX_K).
- Output timing:
  - All outputs are registered. There is no combinational path from stall to any output.
  - While out_valid=1 and stall=1, out_val, out_valid and out_count hold exactly.
- FSM states: LOAD, EMIT, NEXT_LEN, DONE.
  - LOAD (1 cycle):
    - out_val <= big + lo (equals lo·(hi+1), the first value of half-length h).
    - step <= hi + 1; x <= lo; out_valid <= 1; go to EMIT.
  - EMIT, no accept: hold everything.
  - EMIT, accept with x != hi-1:
    - x <= x+1; out_val <= out_val + step; out_valid stays 1.
    - The next value is presented on the following cycle, so the sustained rate is 1 value/clock.
  - EMIT, accept with x == hi-1 (last value of this length):
    - out_valid <= 0.
    - If h == floor(MAX_K/2), go to DONE; otherwise go to NEXT_LEN.
  - NEXT_LEN (1 cycle):
    - h <= h+1; lo <= hi; hi <= (hi<<3)+(hi<<1); big <= (big<<6)+(big<<5)+(big<<2); go to LOAD.
  - DONE:
    - done <= 1; out_valid=0; out_val holds its last value. Remains here until reset.
    - stall is ignored.
- Latency:
  - First out_valid is asserted on the 1st rising edge after rst deasserts (value 11).
  - Between lengths, out_valid is low for exactly 2 cycles (NEXT_LEN, LOAD).
  - done rises 1 cycle after the final accept.
- Arithmetic:
  - All datapath registers are 64-bit unsigned.
  - No overflow is possible for MAX_K ≤ 18; MAX_K > 18 is unsupported.
  - Odd MAX_K behaves as MAX_K-1.
- Ordering:
  - Values are strictly increasing.
  - The last value of length h (10^(2h)-1) is smaller than the first value of length h+1 (10^(2h+1)+10^h).
- Reset mid-operation: asserting rst at any time, including during a stall or in DONE, returns everything to the reset values asynchronously. The sequence then restarts from 11.
- stall is don't-care while out_valid=0.

Test Plan:
- MAX_K=2, stall=0:
  - out_val sequence 11,22,…,99 on consecutive cycles; out_count=9.
  - done=1 one cycle after 99 is accepted; out_valid stays 0 thereafter.
- MAX_K=4, stall=0:
  - After 99, out_valid is low for exactly 2 cycles, then 1010,1111,…,9999.
  - Final out_count=99; sum of accepted values = 495 + 495405 = 495900.
- Stall hold: hold stall=1 for 5 cycles while out_val=33 → out_val=33, out_valid=1, out_count=2 are stable throughout. Releasing stall → 44 on the next cycle.
- Consumer-style stall: stall = (out_val > 5000), released after 10 cycles → 5050 is held, then 5151 follows; no value is skipped or duplicated.
- Reset mid-run: drive rst low asynchronously (off a clock edge) while out_val=2323 → all outputs clear immediately. After release, the first value is 11 on the next edge.
- MAX_K=12 full run:
  - out_count=999999, done=1, last value 999999999999.
  - Every accepted value is checked against a reference model X·(10^h+1).
